// File: rtl/smbm_pkg.sv
// Shared types for the sorted metric bitmap memory.
// The entry layout is also consumed by the downstream ufpu stage.
package smbm_pkg;
    localparam int BIT_VEC_SIZE       = 128;
    localparam int BIT_VEC_SIZE_LOG   = 7;
    localparam int NUM_OF_METRICS     = 4;
    localparam int NUM_OF_METRICS_LOG = 2;

    typedef logic [BIT_VEC_SIZE_LOG-1:0]   ptr_t;
    typedef logic [NUM_OF_METRICS_LOG-1:0] mid_t;
    typedef logic [BIT_VEC_SIZE_LOG:0]     cnt_t;

    typedef struct packed {
        ptr_t        ptr;
        logic [15:0] val;
    } entry_t;

    typedef entry_t [BIT_VEC_SIZE-1:0] list_t;

    typedef enum logic [1:0] {
        OP_NOP    = 2'b00,
        OP_UPDATE = 2'b01,
        OP_DELETE = 2'b10,
        OP_CLEAR  = 2'b11
    } cmd_op_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOCATE,
        S_COMMIT
    } state_e;

    localparam ptr_t   EMPTY_PTR   = '1;
    localparam ptr_t   RSVD_ID     = ptr_t'(BIT_VEC_SIZE - 1);
    localparam entry_t EMPTY_ENTRY = '{ptr: EMPTY_PTR, val: 16'h0};
    localparam list_t  EMPTY_LIST  = {BIT_VEC_SIZE{EMPTY_ENTRY}};
endpackage

// File: rtl/smbm_if.sv
// Command handshake bundle between control software and smbm.
// master = requester, slave = smbm.
interface smbm_if;
    import smbm_pkg::*;

    logic        cmd_valid;
    logic        cmd_ready;
    cmd_op_e     cmd_op;
    mid_t        cmd_metric;
    ptr_t        cmd_id;
    logic [15:0] cmd_val;
    logic        cmd_done;
    logic        cmd_err;

    modport master (
        output cmd_valid, cmd_op, cmd_metric, cmd_id, cmd_val,
        input  cmd_ready, cmd_done, cmd_err
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_metric, cmd_id, cmd_val,
        output cmd_ready, cmd_done, cmd_err
    );
endinterface

// File: rtl/priority_encode_log.sv
// Lowest-index-first priority encoder with a hit flag.
module priority_encode_log #(
    parameter int WIDTH = 128,
    parameter int LOG   = 7
) (
    input  logic [WIDTH-1:0] in_vec,
    output logic [LOG-1:0]   out_idx,
    output logic             out_vld
);
    always_comb begin
        out_idx = '0;
        out_vld = 1'b0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (in_vec[i]) begin
                out_idx = LOG'(i);
                out_vld = 1'b1;
            end
        end
    end
endmodule

// File: rtl/smbm_sorted_list_commit.sv
// Builds the whole post-command list in one pass so a list is never
// observed half-shifted.
module sorted_list_commit
    import smbm_pkg::*;
(
    input  list_t   old_list,
    input  ptr_t    old_pos,
    input  logic    present,
    input  ptr_t    ins_pos,
    input  entry_t  new_entry,
    input  cmd_op_e op,
    output list_t   new_list
);
    list_t up;
    list_t dn;

    // up[i] = old[i+1], dn[i] = old[i-1], empty beyond the ends
    assign up = {EMPTY_ENTRY, old_list[BIT_VEC_SIZE-1:1]};
    assign dn = {old_list[BIT_VEC_SIZE-2:0], EMPTY_ENTRY};

    always_comb begin
        new_list = old_list;
        for (int i = 0; i < BIT_VEC_SIZE; i++) begin
            unique case (op)
                OP_UPDATE: begin
                    if (ptr_t'(i) < ins_pos) begin
                        new_list[i] = (present && ptr_t'(i) >= old_pos)
                                    ? up[i] : old_list[i];
                    end else if (ptr_t'(i) == ins_pos) begin
                        new_list[i] = new_entry;
                    end else begin
                        new_list[i] = (present && ptr_t'(i) > old_pos)
                                    ? old_list[i] : dn[i];
                    end
                end
                OP_DELETE: begin
                    new_list[i] = (present && ptr_t'(i) >= old_pos)
                                ? up[i] : old_list[i];
                end
                OP_CLEAR: new_list[i] = EMPTY_ENTRY;
                default:  new_list[i] = old_list[i];
            endcase
        end
    end
endmodule

// File: rtl/smbm.sv
// Sorted metric bitmap memory: per-metric sorted lists with a
// three-cycle command FSM and an independent registered read port.
module smbm
    import smbm_pkg::*;
(
    input  logic  clk,
    input  logic  rst_n,
    smbm_if.slave bus,
    input  logic  rd_valid,
    input  mid_t  rd_metric,
    output list_t metric_list,
    output logic  list_valid,
    output cnt_t  count
);
    state_e      state_q, state_d;
    cmd_op_e     op_q, op_d;
    mid_t        metric_q, metric_d;
    ptr_t        id_q, id_d;
    logic [15:0] val_q, val_d;
    ptr_t        old_pos_q, old_pos_d;
    logic        present_q, present_d;
    ptr_t        ins_pos_q, ins_pos_d;
    list_t       lists_q [NUM_OF_METRICS];
    list_t       lists_d [NUM_OF_METRICS];
    list_t       metric_list_q, metric_list_d;
    logic        list_valid_q, list_valid_d;
    cnt_t        count_q, count_d;

    list_t                   cur_list;
    list_t                   commit_list;
    logic [BIT_VEC_SIZE-1:0] match;
    logic [BIT_VEC_SIZE-1:0] le;
    ptr_t                    ins_cnt;
    ptr_t                    pe_idx;
    logic                    pe_vld;
    cnt_t                    rd_cnt;
    logic                    err;

    assign cur_list = lists_q[metric_q];

    always_comb begin
        ins_cnt = '0;
        for (int i = 0; i < BIT_VEC_SIZE; i++) begin
            match[i] = cur_list[i].ptr == id_q;
            le[i]    = cur_list[i].ptr != EMPTY_PTR
                    && cur_list[i].ptr != id_q
                    && cur_list[i].val <= val_q;
            ins_cnt  = ins_cnt + {{(BIT_VEC_SIZE_LOG-1){1'b0}}, le[i]};
        end
    end

    priority_encode_log #(
        .WIDTH (BIT_VEC_SIZE),
        .LOG   (BIT_VEC_SIZE_LOG)
    ) u_pe (
        .in_vec  (match),
        .out_idx (pe_idx),
        .out_vld (pe_vld)
    );

    sorted_list_commit u_commit (
        .old_list  (cur_list),
        .old_pos   (old_pos_q),
        .present   (present_q),
        .ins_pos   (ins_pos_q),
        .new_entry ('{ptr: id_q, val: val_q}),
        .op        (op_q),
        .new_list  (commit_list)
    );

    // The reserved id also matches empty slots, so it is rejected outright
    assign err = (op_q == OP_UPDATE || op_q == OP_DELETE)
              && (id_q == RSVD_ID || (op_q == OP_DELETE && !present_q));

    assign bus.cmd_ready = state_q == S_IDLE;
    assign bus.cmd_done  = state_q == S_COMMIT;
    assign bus.cmd_err   = state_q == S_COMMIT && err;

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        metric_d  = metric_q;
        id_d      = id_q;
        val_d     = val_q;
        old_pos_d = old_pos_q;
        present_d = present_q;
        ins_pos_d = ins_pos_q;
        lists_d   = lists_q;
        unique case (state_q)
            S_IDLE: begin
                if (bus.cmd_valid) begin
                    op_d     = bus.cmd_op;
                    metric_d = bus.cmd_metric;
                    id_d     = bus.cmd_id;
                    val_d    = bus.cmd_val;
                    state_d  = S_LOCATE;
                end
            end
            S_LOCATE: begin
                old_pos_d = pe_idx;
                present_d = pe_vld;
                ins_pos_d = ins_cnt;
                state_d   = S_COMMIT;
            end
            S_COMMIT: begin
                if (!err) lists_d[metric_q] = commit_list;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        rd_cnt = '0;
        for (int i = 0; i < BIT_VEC_SIZE; i++) begin
            rd_cnt = rd_cnt + {{BIT_VEC_SIZE_LOG{1'b0}},
                     lists_q[rd_metric][i].ptr != EMPTY_PTR};
        end
        list_valid_d  = rd_valid;
        metric_list_d = rd_valid ? lists_q[rd_metric] : metric_list_q;
        count_d       = rd_valid ? rd_cnt : count_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            op_q          <= OP_NOP;
            metric_q      <= '0;
            id_q          <= '0;
            val_q         <= '0;
            old_pos_q     <= '0;
            present_q     <= 1'b0;
            ins_pos_q     <= '0;
            for (int m = 0; m < NUM_OF_METRICS; m++) lists_q[m] <= EMPTY_LIST;
            metric_list_q <= EMPTY_LIST;
            list_valid_q  <= 1'b0;
            count_q       <= '0;
        end else begin
            state_q       <= state_d;
            op_q          <= op_d;
            metric_q      <= metric_d;
            id_q          <= id_d;
            val_q         <= val_d;
            old_pos_q     <= old_pos_d;
            present_q     <= present_d;
            ins_pos_q     <= ins_pos_d;
            lists_q       <= lists_d;
            metric_list_q <= metric_list_d;
            list_valid_q  <= list_valid_d;
            count_q       <= count_d;
        end
    end

    assign metric_list = metric_list_q;
    assign list_valid  = list_valid_q;
    assign count       = count_q;
endmodule

// File: tb/tb_smbm.sv
// Directed bench for smbm: command timing, sorted order, errors,
// read/commit ordering and reset abort.
module tb_smbm;
    import smbm_pkg::*;

    logic  clk = 1'b0;
    logic  rst_n = 1'b0;
    logic  rd_valid = 1'b0;
    mid_t  rd_metric = '0;
    list_t metric_list;
    logic  list_valid;
    cnt_t  count;

    int checks = 0;
    int failures = 0;

    entry_t exp_l [BIT_VEC_SIZE];
    int     exp_n;

    smbm_if bus();

    smbm dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus.slave),
        .rd_valid    (rd_valid),
        .rd_metric   (rd_metric),
        .metric_list (metric_list),
        .list_valid  (list_valid),
        .count       (count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic exp_clear();
        for (int i = 0; i < BIT_VEC_SIZE; i++) exp_l[i] = EMPTY_ENTRY;
        exp_n = 0;
    endtask

    task automatic exp_push(input int p, input int v);
        exp_l[exp_n] = '{ptr: ptr_t'(p), val: 16'(v)};
        exp_n++;
    endtask

    task automatic check_list(input string tag);
        chk({tag, "_lv"}, {31'd0, list_valid}, 32'd1);
        chk({tag, "_cnt"}, {24'd0, count}, 32'(exp_n));
        for (int i = 0; i < BIT_VEC_SIZE; i++)
            chk($sformatf("%s_e%0d", tag, i),
                {9'd0, metric_list[i]}, {9'd0, exp_l[i]});
    endtask

    task automatic rd(input int m, input string tag);
        @(negedge clk);
        rd_valid  = 1'b1;
        rd_metric = mid_t'(m);
        @(negedge clk);
        rd_valid  = 1'b0;
        check_list(tag);
    endtask

    task automatic do_cmd(input cmd_op_e op, input int m, input int id,
                          input int v, input logic exp_err,
                          input string tag);
        @(negedge clk);
        chk({tag, "_rdy0"}, {31'd0, bus.cmd_ready}, 32'd1);
        bus.cmd_valid  = 1'b1;
        bus.cmd_op     = op;
        bus.cmd_metric = mid_t'(m);
        bus.cmd_id     = ptr_t'(id);
        bus.cmd_val    = 16'(v);
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        chk({tag, "_loc_done"}, {31'd0, bus.cmd_done}, 32'd0);
        chk({tag, "_loc_rdy"}, {31'd0, bus.cmd_ready}, 32'd0);
        @(negedge clk);
        chk({tag, "_done"}, {31'd0, bus.cmd_done}, 32'd1);
        chk({tag, "_err"}, {31'd0, bus.cmd_err}, {31'd0, exp_err});
        @(negedge clk);
        chk({tag, "_rdy3"}, {31'd0, bus.cmd_ready}, 32'd1);
        chk({tag, "_done3"}, {31'd0, bus.cmd_done}, 32'd0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        bus.cmd_valid  = 1'b0;
        bus.cmd_op     = OP_NOP;
        bus.cmd_metric = '0;
        bus.cmd_id     = '0;
        bus.cmd_val    = '0;

        repeat (2) @(negedge clk);
        chk("rst_rdy", {31'd0, bus.cmd_ready}, 32'd1);
        chk("rst_done", {31'd0, bus.cmd_done}, 32'd0);
        chk("rst_err", {31'd0, bus.cmd_err}, 32'd0);
        chk("rst_lv", {31'd0, list_valid}, 32'd0);
        chk("rst_cnt", {24'd0, count}, 32'd0);
        rst_n = 1'b1;

        exp_clear();
        rd(0, "rst_m0");

        do_cmd(OP_UPDATE, 1, 5, 30, 1'b0, "u5");
        do_cmd(OP_UPDATE, 1, 2, 10, 1'b0, "u2");
        do_cmd(OP_UPDATE, 1, 9, 20, 1'b0, "u9");
        exp_clear();
        exp_push(2, 10); exp_push(9, 20); exp_push(5, 30);
        rd(1, "m1_a");

        do_cmd(OP_UPDATE, 1, 2, 25, 1'b0, "u2b");
        exp_clear();
        exp_push(9, 20); exp_push(2, 25); exp_push(5, 30);
        rd(1, "m1_move");

        do_cmd(OP_UPDATE, 1, 7, 25, 1'b0, "u7");
        exp_clear();
        exp_push(9, 20); exp_push(2, 25); exp_push(7, 25); exp_push(5, 30);
        rd(1, "m1_tie");

        do_cmd(OP_DELETE, 1, 9, 0, 1'b0, "d9");
        do_cmd(OP_DELETE, 1, 9, 0, 1'b1, "d9_again");
        do_cmd(OP_UPDATE, 1, 127, 3, 1'b1, "u127");
        do_cmd(OP_NOP, 1, 0, 0, 1'b0, "nop");
        exp_clear();
        exp_push(2, 25); exp_push(7, 25); exp_push(5, 30);
        rd(1, "m1_del");

        // read in LOCATE (metric 0), then metric 1 in COMMIT and after
        @(negedge clk);
        bus.cmd_valid  = 1'b1;
        bus.cmd_op     = OP_UPDATE;
        bus.cmd_metric = 2'd1;
        bus.cmd_id     = 7'd5;
        bus.cmd_val    = 16'd1;
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        rd_valid      = 1'b1;
        rd_metric     = 2'd0;
        @(negedge clk);
        chk("cr_done", {31'd0, bus.cmd_done}, 32'd1);
        exp_clear();
        check_list("cr_m0");
        rd_metric = 2'd1;
        @(negedge clk);
        exp_clear();
        exp_push(2, 25); exp_push(7, 25); exp_push(5, 30);
        check_list("cr_old");
        @(negedge clk);
        rd_valid = 1'b0;
        exp_clear();
        exp_push(5, 1); exp_push(2, 25); exp_push(7, 25);
        check_list("cr_new");

        // reset during LOCATE aborts the command
        @(negedge clk);
        bus.cmd_valid  = 1'b1;
        bus.cmd_op     = OP_UPDATE;
        bus.cmd_metric = 2'd2;
        bus.cmd_id     = 7'd3;
        bus.cmd_val    = 16'd3;
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("ra_done0", {31'd0, bus.cmd_done}, 32'd0);
        @(negedge clk);
        chk("ra_done1", {31'd0, bus.cmd_done}, 32'd0);
        chk("ra_rdy", {31'd0, bus.cmd_ready}, 32'd1);
        rst_n = 1'b1;
        @(negedge clk);
        chk("ra_done2", {31'd0, bus.cmd_done}, 32'd0);
        exp_clear();
        rd(2, "ra_m2");
        rd(1, "ra_m1");

        for (int k = 0; k < 127; k++)
            do_cmd(OP_UPDATE, 3, k, 1000 - k, 1'b0, $sformatf("fill%0d", k));
        exp_clear();
        for (int j = 0; j < 127; j++) exp_push(126 - j, 874 + j);
        rd(3, "full_m3");

        do_cmd(OP_CLEAR, 3, 0, 0, 1'b0, "clr");
        exp_clear();
        rd(3, "clr_m3");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
